// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   localparam logic SC_SUCCESS = 1'b0;
   localparam logic SC_FAIL    = 1'b1;

endpackage

// File: rtl/lr_sc_link_reg.sv
// LR/SC reservation register: holds the linked word, compares it against the
// current access address and drops it on matching invalidations or explicit clears.
module lr_sc_link_reg #(
   parameter int ADDR_W   = 32,
   parameter int GRAN_LSB = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              set_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_i,
   input  logic              inv_valid_i,
   input  logic [ADDR_W-1:0] inv_addr_i,
   input  logic [ADDR_W-1:0] cmp_addr_i,
   output logic              link_valid_o,
   output logic              link_match_o,
   output logic              inv_hit_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inv_on_set;

   assign inv_hit_o    = inv_valid_i && (inv_addr_i[ADDR_W-1:GRAN_LSB] == addr_q[ADDR_W-1:GRAN_LSB]);
   assign inv_on_set   = inv_valid_i && (inv_addr_i[ADDR_W-1:GRAN_LSB] == set_addr_i[ADDR_W-1:GRAN_LSB]);
   assign link_match_o = valid_q && (cmp_addr_i[ADDR_W-1:GRAN_LSB] == addr_q[ADDR_W-1:GRAN_LSB]);
   assign link_valid_o = valid_q;

   // A new LR replaces any old reservation; a same-cycle invalidation of its word leaves it unset.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (set_i) begin
         valid_d = !inv_on_set;
         addr_d  = set_addr_i;
      end else if (clr_i || inv_hit_o) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage request controller: sequences dcache loads/stores/LR/SC, stalls the
// pipeline until completion and returns load data or the SC result.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int GRAN_LSB = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              atomic,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   input  logic              inv_valid,
   input  logic [ADDR_W-1:0] inv_addr,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [ADDR_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic              mem_done,
   output logic [DATA_W-1:0] rdata,
   output logic              link_valid
);

   mem_state_t        state_q, state_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              req, is_lr, is_sc, sc_ok;
   logic              link_set, link_clr, link_match, inv_hit;

   assign req   = mem_read || mem_write;
   assign is_lr = atomic && mem_read;
   assign is_sc = atomic && mem_write;
   // An invalidation arriving with the SC beats the reservation.
   assign sc_ok = link_match && !inv_hit;

   lr_sc_link_reg #(
      .ADDR_W   (ADDR_W),
      .GRAN_LSB (GRAN_LSB)
   ) u_link (
      .clk_i        (CLK),
      .rst_ni       (nRST),
      .set_i        (link_set),
      .set_addr_i   (addr),
      .clr_i        (link_clr),
      .inv_valid_i  (inv_valid),
      .inv_addr_i   (inv_addr),
      .cmp_addr_i   (addr),
      .link_valid_o (link_valid),
      .link_match_o (link_match),
      .inv_hit_o    (inv_hit)
   );

   always_comb begin
      state_d  = state_q;
      rdata_d  = rdata_q;
      link_set = 1'b0;
      link_clr = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (is_sc && !sc_ok) begin
                  state_d  = DONE;
                  rdata_d  = {{(DATA_W-1){1'b0}}, SC_FAIL};
                  link_clr = 1'b1;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (dhit) begin
               state_d  = DONE;
               link_set = is_lr;
               link_clr = is_sc || (mem_write && link_match);
               if (mem_read)   rdata_d = dmemload;
               else if (is_sc) rdata_d = {{(DATA_W-1){1'b0}}, SC_SUCCESS};
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   // Stall is qualified by reset so an abandoned request cannot hold the pipe.
   assign mem_stall = nRST && (((state_q == IDLE) && req) || (state_q == ACCESS));
   assign mem_done  = (state_q == DONE);
   assign dmemREN   = (state_q == ACCESS) && mem_read;
   assign dmemWEN   = (state_q == ACCESS) && mem_write;
   assign dmemaddr  = addr;
   assign dmemstore = store_data;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, LR/SC success and failure paths,
// invalidation races, own-store link clear and reset mid-access.
module tb_mem_access_ctrl;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        mem_read, mem_write, atomic, dhit, inv_valid;
   logic [31:0] addr, store_data, dmemload, inv_addr;
   logic        dmemREN, dmemWEN, mem_stall, mem_done, link_valid;
   logic [31:0] dmemaddr, dmemstore, rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   mem_access_ctrl dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .atomic     (atomic),
      .addr       (addr),
      .store_data (store_data),
      .dhit       (dhit),
      .dmemload   (dmemload),
      .inv_valid  (inv_valid),
      .inv_addr   (inv_addr),
      .dmemREN    (dmemREN),
      .dmemWEN    (dmemWEN),
      .dmemaddr   (dmemaddr),
      .dmemstore  (dmemstore),
      .mem_stall  (mem_stall),
      .mem_done   (mem_done),
      .rdata      (rdata),
      .link_valid (link_valid)
   );

   task automatic drop_inputs();
      mem_read = 0; mem_write = 0; atomic = 0; dhit = 0; inv_valid = 0;
      addr = 0; store_data = 0; dmemload = 0; inv_addr = 0;
   endtask

   // Drives one request from posedge+1 until mem_done (bounded); cycle 0 is the request cycle.
   task automatic access(input logic rd, input logic wr, input logic at,
                         input logic [31:0] a, input logic [31:0] d, input int hit_cyc,
                         input logic [31:0] load, input int inv_cyc, input logic [31:0] inv_a,
                         output int stall_n, output int lat, output logic ren_seen,
                         output logic wen_seen, output logic [31:0] store_seen,
                         output logic [31:0] rd_seen);
      bit fin = 0;
      mem_read = rd; mem_write = wr; atomic = at; addr = a; store_data = d;
      stall_n = 0; lat = -1; ren_seen = 0; wen_seen = 0; store_seen = 'x; rd_seen = 'x;
      for (int c = 0; c < 30 && !fin; c++) begin
         dhit = (c == hit_cyc); dmemload = load;
         inv_valid = (c == inv_cyc); inv_addr = inv_a;
         @(negedge CLK);
         if (mem_stall) stall_n++;
         if (dmemREN) ren_seen = 1;
         if (dmemWEN) begin wen_seen = 1; store_seen = dmemstore; end
         if (mem_done) begin lat = c; rd_seen = rdata; fin = 1; end
         @(posedge CLK); #1;
      end
      drop_inputs();
   endtask

   task automatic pulse_inv(input logic [31:0] a);
      inv_valid = 1; inv_addr = a;
      @(posedge CLK); #1;
      inv_valid = 0;
   endtask

   int st, lt; logic rs, ws; logic [31:0] ss, rv;

   task automatic test_reset();
      @(negedge CLK); n_cmp++;
      if ({link_valid, dmemREN, dmemWEN, mem_stall, mem_done} !== 5'b0 || rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got lv/ren/wen/stall/done=%b rdata=%h want 00000 / 0",
                  {link_valid, dmemREN, dmemWEN, mem_stall, mem_done}, rdata);
      end
      @(posedge CLK); #1; nRST = 1;
   endtask

   task automatic test_load();
      access(1, 0, 0, 32'h100, 0, 3, 32'hDEADBEEF, -1, 0, st, lt, rs, ws, ss, rv);
      n_cmp++; if (st !== 4)  begin n_bad++; $display("FAIL lw_stall: got %0d want 4", st); end
      n_cmp++; if (lt !== 4)  begin n_bad++; $display("FAIL lw_latency: got %0d want 4", lt); end
      n_cmp++; if (rs !== 1'b1 || ws !== 1'b0) begin n_bad++; $display("FAIL lw_enables: ren=%b wen=%b want 1/0", rs, ws); end
      n_cmp++; if (rv !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", rv); end
      @(negedge CLK); n_cmp++;
      if (mem_done !== 1'b0 || mem_stall !== 1'b0) begin n_bad++; $display("FAIL lw_done_pulse: done=%b stall=%b want 0/0", mem_done, mem_stall); end
      @(posedge CLK); #1;
   endtask

   task automatic test_lr_sc_ok();
      access(1, 0, 1, 32'h200, 0, 1, 32'h11, -1, 0, st, lt, rs, ws, ss, rv);
      n_cmp++; if (link_valid !== 1'b1) begin n_bad++; $display("FAIL lr_link_set: got %b want 1", link_valid); end
      n_cmp++; if (rv !== 32'h11) begin n_bad++; $display("FAIL lr_rdata: got %h want 11", rv); end
      access(0, 1, 1, 32'h200, 32'h5, 2, 0, -1, 0, st, lt, rs, ws, ss, rv);
      n_cmp++; if (ws !== 1'b1 || ss !== 32'h5) begin n_bad++; $display("FAIL sc_write: wen=%b store=%h want 1/5", ws, ss); end
      n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL sc_ok_rdata: got %h want 0", rv); end
      n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL sc_link_clr: got %b want 0", link_valid); end
   endtask

   task automatic test_inv();
      access(1, 0, 1, 32'h200, 0, 1, 32'h22, -1, 0, st, lt, rs, ws, ss, rv);
      pulse_inv(32'h204);
      n_cmp++; if (link_valid !== 1'b1) begin n_bad++; $display("FAIL inv_other_word: link=%b want 1", link_valid); end
      pulse_inv(32'h200);
      n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL inv_same_word: link=%b want 0", link_valid); end
      access(0, 1, 1, 32'h200, 32'h7, 1, 0, -1, 0, st, lt, rs, ws, ss, rv);
      n_cmp++; if (ws !== 1'b0) begin n_bad++; $display("FAIL sc_fail_nowrite: wen=%b want 0", ws); end
      n_cmp++; if (rv !== 32'h1) begin n_bad++; $display("FAIL sc_fail_rdata: got %h want 1", rv); end
      n_cmp++; if (lt !== 1) begin n_bad++; $display("FAIL sc_fail_latency: got %0d want 1", lt); end
   endtask

   task automatic test_sc_nolink();
      access(0, 1, 1, 32'h300, 32'h9, 1, 0, -1, 0, st, lt, rs, ws, ss, rv);
      n_cmp++; if (ws !== 1'b0 || rv !== 32'h1) begin n_bad++; $display("FAIL sc_nolink: wen=%b rdata=%h want 0/1", ws, rv); end
      access(1, 0, 1, 32'h300, 0, 1, 32'h33, -1, 0, st, lt, rs, ws, ss, rv);
      access(0, 1, 1, 32'h300, 32'h9, 1, 0, 0, 32'h300, st, lt, rs, ws, ss, rv);
      n_cmp++; if (ws !== 1'b0 || rv !== 32'h1) begin n_bad++; $display("FAIL sc_inv_race: wen=%b rdata=%h want 0/1", ws, rv); end
      n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL sc_inv_race_link: got %b want 0", link_valid); end
      // Invalidation on the LR's own dhit cycle.
      access(1, 0, 1, 32'h700, 0, 1, 32'h77, 1, 32'h700, st, lt, rs, ws, ss, rv);
      n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL lr_inv_race: link=%b want 0", link_valid); end
      // Invalidation while SC is already in ACCESS does not abort it.
      access(1, 0, 1, 32'h800, 0, 1, 32'h88, -1, 0, st, lt, rs, ws, ss, rv);
      access(0, 1, 1, 32'h800, 32'hAB, 2, 0, 1, 32'h800, st, lt, rs, ws, ss, rv);
      n_cmp++; if (ws !== 1'b1 || rv !== 32'h0) begin n_bad++; $display("FAIL sc_inv_in_access: wen=%b rdata=%h want 1/0", ws, rv); end
   endtask

   task automatic test_own_store();
      access(1, 0, 1, 32'h400, 0, 1, 32'h44, -1, 0, st, lt, rs, ws, ss, rv);
      access(0, 1, 0, 32'h400, 32'h1, 1, 0, -1, 0, st, lt, rs, ws, ss, rv);
      n_cmp++; if (link_valid !== 1'b0) begin n_bad++; $display("FAIL own_store_clr: link=%b want 0", link_valid); end
      access(1, 0, 1, 32'h400, 0, 1, 32'h45, -1, 0, st, lt, rs, ws, ss, rv);
      access(0, 1, 0, 32'h500, 32'h2, 2, 0, -1, 0, st, lt, rs, ws, ss, rv);
      n_cmp++; if (link_valid !== 1'b1) begin n_bad++; $display("FAIL other_store_keep: link=%b want 1", link_valid); end
      n_cmp++; if (rv !== 32'h45) begin n_bad++; $display("FAIL store_rdata_hold: got %h want 45", rv); end
      n_cmp++; if (lt !== 3 || ws !== 1'b1) begin n_bad++; $display("FAIL sw_latency: lat=%0d wen=%b want 3/1", lt, ws); end
   endtask

   task automatic test_reset_mid();
      access(1, 0, 1, 32'h900, 0, 1, 32'h99, -1, 0, st, lt, rs, ws, ss, rv);
      mem_write = 1; addr = 32'h600; store_data = 32'h66;
      @(posedge CLK); #1;
      @(negedge CLK); n_cmp++;
      if (dmemWEN !== 1'b1 || link_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset: wen=%b link=%b want 1/1", dmemWEN, link_valid); end
      #2 nRST = 0;
      #1 n_cmp++;
      if (dmemWEN !== 1'b0 || mem_stall !== 1'b0 || link_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid: wen=%b stall=%b link=%b want 0/0/0", dmemWEN, mem_stall, link_valid);
      end
      @(posedge CLK); #1; drop_inputs(); nRST = 1;
      access(1, 0, 0, 32'hA00, 0, 1, 32'hCAFE, -1, 0, st, lt, rs, ws, ss, rv);
      n_cmp++; if (lt !== 2 || rv !== 32'hCAFE) begin n_bad++; $display("FAIL restart: lat=%0d rdata=%h want 2/cafe", lt, rv); end
   endtask

   initial begin
      nRST = 0; drop_inputs();
      test_reset();
      test_load();
      test_lr_sc_ok();
      test_inv();
      test_sc_nolink();
      test_own_store();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
